// File: rtl/fp_pkg.sv
// Floating-point package shared by the FP datapath blocks.
//   fp16_t      : IEEE-754 binary16 {sig, exp, man}
//   fp_flags_t  : per-result exception flags {invalid, overflow, underflow, inexact}
//   fp_class_e  : operand classification
//   fp_classify : classifies an operand from width-independent field summaries
//                 computed by the caller at its own field widths.
package fp_pkg;

   typedef struct packed {
      logic       sig;
      logic [4:0] exp;
      logic [9:0] man;
   } fp16_t;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_SUB,
      FP_NORM,
      FP_INF,
      FP_QNAN,
      FP_SNAN
   } fp_class_e;

   function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                             input logic man_zero, input logic man_msb);
      if (exp_zero) return man_zero ? FP_ZERO : FP_SUB;
      if (exp_ones) return man_zero ? FP_INF : (man_msb ? FP_QNAN : FP_SNAN);
      return FP_NORM;
   endfunction

endpackage

// File: rtl/float_multi_pipe_if.sv
// Handshake/data bundle of float_multi_pipe.
//   request : in_valid_i, in_ready_o, opa_i, opb_i, tag_i
//   response: out_valid_o, out_ready_i, result_o, tag_o, flags_o
//   slave modport is the multiplier side, master modport the issuing side.
interface float_multi_pipe_if
   import fp_pkg::*;
#(
   parameter type fp_t  = fp_pkg::fp16_t,
   parameter int  TAG_W = 4
);
   logic             in_valid_i;
   logic             in_ready_o;
   fp_t              opa_i;
   fp_t              opb_i;
   logic [TAG_W-1:0] tag_i;
   logic             out_valid_o;
   logic             out_ready_i;
   fp_t              result_o;
   logic [TAG_W-1:0] tag_o;
   fp_flags_t        flags_o;

   modport slave (
      input  in_valid_i, opa_i, opb_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, tag_o, flags_o
   );

   modport master (
      output in_valid_i, opa_i, opb_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, tag_o, flags_o
   );
endinterface

// File: rtl/float_round.sv
// Combinational normalise / round / pack for a finite nonzero product.
//   sign_i   : result sign
//   exp_i    : biased exponent before normalisation, two's complement EXPW+2 bits
//   prod_i   : (MW+1)x(MW+1) significand product, 2*MW+2 bits, value in [1,4)
//   result_o : packed result (inf on overflow, signed zero on underflow)
//   flags_o  : overflow / underflow / inexact (invalid never set here)
// Rounding: FLOAT_MULTI_PIPE_RNE_EN defined -> round-to-nearest-even,
//           undefined -> round-toward-zero.
module float_round
   import fp_pkg::*;
#(
   parameter type fp_t = fp_pkg::fp16_t,
   parameter int  MW   = 10,
   parameter int  EXPW = 5,
   localparam int EW   = EXPW + 2,
   localparam int PW   = 2 * MW + 2
) (
   input  logic          sign_i,
   input  logic [EW-1:0] exp_i,
   input  logic [PW-1:0] prod_i,
   output fp_t           result_o,
   output fp_flags_t     flags_o
);
   localparam logic signed [EW-1:0] MAX_E = EW'(2**EXPW - 1);

   logic [PW-2:0]         norm;
   logic [MW-1:0]         man;
   logic                  guard, sticky, inc;
   logic [MW:0]           man_r;
   logic signed [EW-1:0]  e_n, e_r;

   always_comb begin
      // Drop the leading one; if the product is >= 2 the point moves one place left.
      norm   = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
      e_n    = $signed(exp_i) + $signed(EW'(prod_i[PW-1]));
      man    = norm[2*MW:MW+1];
      guard  = norm[MW];
      sticky = |norm[MW-1:0];
`ifdef FLOAT_MULTI_PIPE_RNE_EN
      inc    = guard & (sticky | man[0]);
`else
      inc    = 1'b0;
`endif
      man_r  = {1'b0, man} + (MW+1)'(inc);
      // A carry out leaves man_r[MW-1:0] all zero, i.e. 1.0 at the next exponent.
      e_r    = e_n + $signed(EW'(man_r[MW]));

      result_o = {sign_i, e_r[EXPW-1:0], man_r[MW-1:0]};
      flags_o  = '{invalid: 1'b0, overflow: 1'b0, underflow: 1'b0, inexact: guard | sticky};
      if (e_n >= MAX_E || e_r >= MAX_E) begin
         result_o = {sign_i, {EXPW{1'b1}}, {MW{1'b0}}};
         flags_o  = '{invalid: 1'b0, overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
      end else if (e_n[EW-1] || e_n == '0) begin
         result_o = {sign_i, {(EXPW+MW){1'b0}}};
         flags_o  = '{invalid: 1'b0, overflow: 1'b0, underflow: 1'b1, inexact: 1'b1};
      end
   end
endmodule

// File: rtl/float_multi_pipe.sv
// Three-stage valid/ready floating-point multiplier with tag pass-through.
//   clk_i   : clock, rising edge
//   arst_ni : asynchronous active-low reset, clears every stage
//   bus     : float_multi_pipe_if.slave (operands/tag in, result/tag/flags out)
// S1 classify + exponent sum + special-case decision, S2 significand multiply,
// S3 normalise/round/pack. Subnormal inputs are read as signed zero and tiny
// results flush to zero. Rounding mode selected by FLOAT_MULTI_PIPE_RNE_EN.
module float_multi_pipe
   import fp_pkg::*;
#(
   parameter type fp_t  = fp16_t,
   parameter int  TAG_W = 4
) (
   input  logic               clk_i,
   input  logic               arst_ni,
   float_multi_pipe_if.slave  bus
);
   localparam fp_t FP_ONES   = '1;
   localparam int  MW        = $bits(FP_ONES.man);
   localparam int  EXPW      = $bits(FP_ONES.exp);
   localparam int  EW        = EXPW + 2;
   localparam int  PW        = 2 * MW + 2;
   localparam int  BIAS      = 2**(EXPW-1) - 1;
   localparam fp_t CANON_NAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   fp_t              opa, opb;
   fp_class_e        ca, cb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_snan, sign_in;
   logic             spec_in;
   fp_t              spec_res_in;
   fp_flags_t        spec_flg_in;
   logic             ld1, ld2, ld3;

   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic             sign1_q, sign1_d, sign2_q, sign2_d;
   logic [EW-1:0]    e1_q, e1_d, e2_q, e2_d;
   logic [MW:0]      ma1_q, ma1_d, mb1_q, mb1_d;
   logic [PW-1:0]    prod2_q, prod2_d;
   logic             spec1_q, spec1_d, spec2_q, spec2_d;
   fp_t              sres1_q, sres1_d, sres2_q, sres2_d, res3_q, res3_d;
   fp_flags_t        sflg1_q, sflg1_d, sflg2_q, sflg2_d, flg3_q, flg3_d;
   logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   fp_t              rnd_res;
   fp_flags_t        rnd_flg;

   assign opa = bus.opa_i;
   assign opb = bus.opb_i;

   // Ready ripples back combinationally so a full pipe still streams one op per cycle.
   assign ld3 = !v3_q || bus.out_ready_i;
   assign ld2 = !v2_q || ld3;
   assign ld1 = !v1_q || ld2;

   always_comb begin
      ca       = fp_classify(opa.exp == '0, opa.exp == '1, opa.man == '0, opa.man[MW-1]);
      cb       = fp_classify(opb.exp == '0, opb.exp == '1, opb.man == '0, opb.man[MW-1]);
      a_zero   = (ca == FP_ZERO) || (ca == FP_SUB);
      b_zero   = (cb == FP_ZERO) || (cb == FP_SUB);
      a_inf    = (ca == FP_INF);
      b_inf    = (cb == FP_INF);
      a_nan    = (ca == FP_QNAN) || (ca == FP_SNAN);
      b_nan    = (cb == FP_QNAN) || (cb == FP_SNAN);
      any_snan = (ca == FP_SNAN) || (cb == FP_SNAN);
      sign_in  = opa.sig ^ opb.sig;

      spec_in     = 1'b1;
      spec_res_in = '0;
      spec_flg_in = '0;
      if (a_nan || b_nan) begin
         spec_res_in         = CANON_NAN;
         spec_flg_in.invalid = any_snan;
      end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
         spec_res_in         = CANON_NAN;
         spec_flg_in.invalid = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_res_in = {sign_in, {EXPW{1'b1}}, {MW{1'b0}}};
      end else if (a_zero || b_zero) begin
         spec_res_in = {sign_in, {(EXPW+MW){1'b0}}};
      end else begin
         spec_in = 1'b0;
      end
   end

   always_comb begin
      v1_d = v1_q;  sign1_d = sign1_q;  e1_d = e1_q;  ma1_d = ma1_q;  mb1_d = mb1_q;
      spec1_d = spec1_q;  sres1_d = sres1_q;  sflg1_d = sflg1_q;  tag1_d = tag1_q;
      v2_d = v2_q;  sign2_d = sign2_q;  e2_d = e2_q;  prod2_d = prod2_q;
      spec2_d = spec2_q;  sres2_d = sres2_q;  sflg2_d = sflg2_q;  tag2_d = tag2_q;
      v3_d = v3_q;  res3_d = res3_q;  flg3_d = flg3_q;  tag3_d = tag3_q;

      if (ld1) begin
         v1_d = bus.in_valid_i;
         if (bus.in_valid_i) begin
            sign1_d = sign_in;
            e1_d    = EW'(opa.exp) + EW'(opb.exp) - EW'(BIAS);
            ma1_d   = {1'b1, opa.man};
            mb1_d   = {1'b1, opb.man};
            spec1_d = spec_in;
            sres1_d = spec_res_in;
            sflg1_d = spec_flg_in;
            tag1_d  = bus.tag_i;
         end
      end
      if (ld2) begin
         v2_d = v1_q;
         if (v1_q) begin
            sign2_d = sign1_q;
            e2_d    = e1_q;
            prod2_d = PW'(ma1_q) * PW'(mb1_q);
            spec2_d = spec1_q;
            sres2_d = sres1_q;
            sflg2_d = sflg1_q;
            tag2_d  = tag1_q;
         end
      end
      if (ld3) begin
         v3_d = v2_q;
         if (v2_q) begin
            res3_d = spec2_q ? sres2_q : rnd_res;
            flg3_d = spec2_q ? sflg2_q : rnd_flg;
            tag3_d = tag2_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         v1_q <= 1'b0;  sign1_q <= 1'b0;  e1_q <= '0;  ma1_q <= '0;  mb1_q <= '0;
         spec1_q <= 1'b0;  sres1_q <= '0;  sflg1_q <= '0;  tag1_q <= '0;
         v2_q <= 1'b0;  sign2_q <= 1'b0;  e2_q <= '0;  prod2_q <= '0;
         spec2_q <= 1'b0;  sres2_q <= '0;  sflg2_q <= '0;  tag2_q <= '0;
         v3_q <= 1'b0;  res3_q <= '0;  flg3_q <= '0;  tag3_q <= '0;
      end else begin
         v1_q <= v1_d;  sign1_q <= sign1_d;  e1_q <= e1_d;  ma1_q <= ma1_d;  mb1_q <= mb1_d;
         spec1_q <= spec1_d;  sres1_q <= sres1_d;  sflg1_q <= sflg1_d;  tag1_q <= tag1_d;
         v2_q <= v2_d;  sign2_q <= sign2_d;  e2_q <= e2_d;  prod2_q <= prod2_d;
         spec2_q <= spec2_d;  sres2_q <= sres2_d;  sflg2_q <= sflg2_d;  tag2_q <= tag2_d;
         v3_q <= v3_d;  res3_q <= res3_d;  flg3_q <= flg3_d;  tag3_q <= tag3_d;
      end
   end

   float_round #(.fp_t(fp_t), .MW(MW), .EXPW(EXPW)) u_round (
      .sign_i   (sign2_q),
      .exp_i    (e2_q),
      .prod_i   (prod2_q),
      .result_o (rnd_res),
      .flags_o  (rnd_flg)
   );

   assign bus.in_ready_o  = ld1;
   assign bus.out_valid_o = v3_q;
   assign bus.result_o    = res3_q;
   assign bus.tag_o       = tag3_q;
   assign bus.flags_o     = flg3_q;
endmodule

// File: tb/tb_float_multi_pipe.sv
// Scoreboard bench for float_multi_pipe (fp16, TAG_W=4).
module tb_float_multi_pipe;
   import fp_pkg::*;

   logic        clk = 1'b0;
   logic        arst_ni = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] opa = '0, opb = '0;
   logic [3:0]  tag = '0;
   logic        out_ready = 1'b1;
   int          rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

   float_multi_pipe_if #(.fp_t(fp16_t), .TAG_W(4)) bus ();

   assign bus.in_valid_i  = in_valid;
   assign bus.opa_i       = opa;
   assign bus.opb_i       = opb;
   assign bus.tag_i       = tag;
   assign bus.out_ready_i = out_ready;

   float_multi_pipe #(.fp_t(fp16_t), .TAG_W(4)) dut (
      .clk_i   (clk),
      .arst_ni (arst_ni),
      .bus     (bus.slave)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flg;
      logic [3:0]  tag;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, errors = 0, cyc = 0, out_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic real pow2(input int e);
      real r = 1.0;
      for (int i = 0; i < e; i++) r = r * 2.0;
      for (int i = 0; i > e; i--) r = r / 2.0;
      return r;
   endfunction

   // Reference: exact real product, then rounded to binary16 by the arithmetic rules.
   function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic [3:0] f);
      logic s = a[15] ^ b[15];
      int   ea = int'(a[14:10]), eb = int'(b[14:10]);
      int   ma = int'(a[9:0]), mb = int'(b[9:0]);
      bit   a_nan = (ea == 31) && (ma != 0), b_nan = (eb == 31) && (mb != 0);
      bit   a_inf = (ea == 31) && (ma == 0), b_inf = (eb == 31) && (mb == 0);
      bit   a_zero = (ea == 0), b_zero = (eb == 0);
      real  va, vb, p, sc, fr;
      int   e, t;
      bit   inexact;
      f = 4'b0000;
      r = 16'h0000;
      if (a_nan || b_nan) begin
         r = 16'h7E00;
         f[3] = (a_nan && a[9] == 1'b0) || (b_nan && b[9] == 1'b0);
      end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
         r = 16'h7E00; f = 4'b1000;
      end else if (a_inf || b_inf) begin
         r = {s, 15'h7C00};
      end else if (a_zero || b_zero) begin
         r = {s, 15'h0000};
      end else begin
         va = (1.0 + $itor(ma) / 1024.0) * pow2(ea - 15);
         vb = (1.0 + $itor(mb) / 1024.0) * pow2(eb - 15);
         p  = va * vb;
         e  = 0;
         while (p >= pow2(e + 1)) e++;
         while (p < pow2(e)) e--;
         e  = e + 15;
         if (e >= 31) begin
            r = {s, 15'h7C00}; f = 4'b0101;
         end else if (e <= 0) begin
            r = {s, 15'h0000}; f = 4'b0011;
         end else begin
            sc = (p / pow2(e - 15) - 1.0) * 1024.0;
            t  = $rtoi(sc);
            fr = sc - $itor(t);
            inexact = (fr != 0.0);
`ifdef FLOAT_MULTI_PIPE_RNE_EN
            if (fr > 0.5 || (fr == 0.5 && (t % 2) == 1)) t++;
`endif
            if (t == 1024) begin t = 0; e++; end
            if (e >= 31) begin
               r = {s, 15'h7C00}; f = 4'b0101;
            end else begin
               r = {s, 5'(e), 10'(t)};
               f = {3'b000, inexact};
            end
         end
      end
   endfunction

   function automatic logic [15:0] rnd_op();
      int          k = $urandom_range(0, 9);
      logic [15:0] v = 16'($urandom);
      if (k < 6)       v[14:10] = 5'($urandom_range(7, 23));
      else if (k == 7) v[14:10] = 5'h00;
      else if (k == 8) v[14:0]  = 15'h7C00;
      else if (k == 9) v[14:10] = 5'h1F;
      return v;
   endfunction

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                        input logic [15:0] r, input logic [3:0] f, input bit lat);
      int n = 0;
      bit done = 0;
      opa = a; opb = b; tag = t; in_valid = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         if (bus.in_ready_o) begin
            exp_q.push_back('{res: r, flg: f, tag: t, acc: cyc, lat: lat});
            done = 1;
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!done) chk("issue_timeout", n, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial forever begin
      @(posedge clk); #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   initial begin
      bit          held;
      logic [15:0] hr;
      logic [3:0]  hf, ht;
      exp_t        e;
      held = 0; hr = '0; hf = '0; ht = '0;
      forever begin
         @(negedge clk);
         if (!arst_ni) begin
            held = 0;
         end else if (bus.out_valid_o) begin
            if (held) begin
               chk("hold_result", bus.result_o, hr);
               chk("hold_flags", bus.flags_o, hf);
               chk("hold_tag", bus.tag_o, ht);
            end
            hr = bus.result_o; hf = bus.flags_o; ht = bus.tag_o;
            held = !out_ready;
            if (out_ready) begin
               out_count++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  chk("result", bus.result_o, e.res);
                  chk("flags", bus.flags_o, e.flg);
                  chk("tag", bus.tag_o, e.tag);
                  if (e.lat) chk("latency", cyc - e.acc, 3);
               end
            end
         end else begin
            held = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a, b, r, rnd_exp;
      logic [3:0]  f;
      int          k, acc, out0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_result", bus.result_o, 0);
      chk("rst_tag", bus.tag_o, 0);
      chk("rst_flags", bus.flags_o, 0);
      chk("rst_in_ready", bus.in_ready_o, 1);
      @(posedge clk); #2;
      arst_ni = 1'b1;
      @(posedge clk); #1;

`ifdef FLOAT_MULTI_PIPE_RNE_EN
      rnd_exp = 16'h3E02;
`else
      rnd_exp = 16'h3E01;
`endif
      issue(16'h3C00, 16'h4000, 4'd0, 16'h4000, 4'b0000, 1);
      issue(16'h3E00, 16'h3E00, 4'd1, 16'h4080, 4'b0000, 1);
      issue(16'h3C01, 16'h3E00, 4'd2, rnd_exp,  4'b0001, 1);
      issue(16'h7C00, 16'h0000, 4'd3, 16'h7E00, 4'b1000, 1);
      issue(16'hFC00, 16'h4000, 4'd4, 16'hFC00, 4'b0000, 1);
      issue(16'h7D00, 16'h3C00, 4'd5, 16'h7E00, 4'b1000, 1);
      issue(16'h7E00, 16'h3C00, 4'd6, 16'h7E00, 4'b0000, 1);
      issue(16'h7BFF, 16'h4000, 4'd7, 16'h7C00, 4'b0101, 1);
      issue(16'h0400, 16'h3800, 4'd8, 16'h0000, 4'b0011, 1);
      issue(16'h8001, 16'h3C00, 4'd9, 16'h8000, 4'b0000, 1);
      drain();

      // Backpressure: five back-to-back requests against a stalled consumer.
      rdy_mode = 1;
      @(posedge clk); #1;
      out0 = out_count; k = 1; acc = 0;
      opa = 16'h3C00; opb = 16'h4000 + 16'(k); tag = 4'(k); in_valid = 1'b1;
      for (int i = 0; i < 60 && k <= 5; i++) begin
         if (i == 10) begin
            chk("bp_accepted", acc, 3);
            chk("bp_in_ready", bus.in_ready_o, 0);
            chk("bp_out_valid", bus.out_valid_o, 1);
            rdy_mode = 0;
         end
         @(negedge clk);
         if (bus.in_ready_o) begin
            exp_q.push_back('{res: 16'h4000 + 16'(k), flg: 4'b0000, tag: 4'(k), acc: cyc, lat: 0});
            acc++; k++;
         end
         @(posedge clk); #1;
         if (k <= 5) begin
            opb = 16'h4000 + 16'(k); tag = 4'(k);
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", k, 6);
      drain();
      chk("bp_outputs", out_count - out0, 5);

      // Random stream with random backpressure and a reset pulse mid-stream.
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         if (i == 150) begin
            #1;
            arst_ni = 1'b0;
            exp_q.delete();
            @(negedge clk);
            chk("mid_rst_out_valid", bus.out_valid_o, 0);
            chk("mid_rst_in_ready", bus.in_ready_o, 1);
            @(posedge clk); #2;
            arst_ni = 1'b1;
            @(posedge clk); #1;
         end
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
         end
         a = rnd_op();
         b = rnd_op();
         ref_mul(a, b, r, f);
         issue(a, b, 4'(i), r, f, 0);
      end
      rdy_mode = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/float_multi_pipe.md
Name: float_multi_pipe

Overview:
- Pipelined, valid/ready floating-point multiplier: successor to the combinational multiplier.
- Parametrised on fp_t, with a tag pass-through for out-of-order bookkeeping.
- Full IEEE-754 special-case handling, FTZ/DAZ, exception flags and round-to-nearest-even.
- Sits between operand-issue logic and the FP writeback arbiter; sustains one operation per cycle.

Parameters:
- fp_t, fp_pkg::fp16_t, floating-point type (sig/exp/man struct); MW=$bits(man), EXPW=$bits(exp), BIAS=2^(EXPW-1)-1.
- TAG_W, 4, width of the opaque tag carried alongside each operation (minimum 1).

Ports:
- clk_i  input  1  clock, rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  block can accept operands this cycle.
- opa_i  input  fp_t  operand A.
- opb_i  input  fp_t  operand B.
- tag_i  input  TAG_W  request tag.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  fp_t  product.
- tag_o  output  TAG_W  tag of result.
- flags_o  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on arst_ni; all pipeline valid and data registers clear to 0. out_valid_o=0, result_o=0, tag_o=0, flags_o=0, in_ready_o=1 after reset.
- Reset mid-operation discards every in-flight operation; no partial result is emitted.
- Pipeline: 3 register stages. Latency is 3 cycles from input handshake to out_valid_o when there is no backpressure.
  - S1: unpack, classify (zero/sub/normal/inf/NaN), sign=sa^sb, exponent sum e=ea+eb-BIAS as signed EXPW+2 bits, special-case decision.
  - S2: (MW+1)x(MW+1) mantissa multiply, 2*MW+2-bit product.
  - S3: normalise (MSB set -> shift right 1, e+1), round, overflow/underflow check, pack.
- Handshake: stage k loads when its valid=0 or stage k+1 loads this cycle; S3 advances on out_ready_i. in_ready_o = !v1 | S1 advancing (combinational through the pipeline).
  - Full throughput with out_ready_i held high.
  - With out_ready_i low, exactly 3 operations are accepted, then in_ready_o=0.
  - result_o/tag_o/flags_o stay stable while out_valid_o=1 and out_ready_i=0.
  - Transfer only on valid&ready at either port.
- Subnormal inputs are treated as signed zero (DAZ).
- Special cases, in priority order:
  - Any NaN operand -> canonical NaN {0, MAX_EXP, 1<<(MW-1)}. Invalid is set only if the NaN is signalling (man MSB=0).
  - 0 x inf -> canonical NaN, invalid.
  - inf x finite-nonzero, or inf x inf -> signed inf.
  - Zero x finite -> signed zero.
- Normal path:
  - After normalise: if e>=MAX_EXP -> signed inf, overflow+inexact. If e<=0 -> signed zero (FTZ), underflow+inexact.
  - Guard/sticky are taken from the discarded product bits. Inexact = any discarded bit nonzero.
  - A rounding carry out of the mantissa increments e, and overflow is re-checked after that increment.
- Flags are per-result, valid with out_valid_o; they are not sticky.

Optional Feature:
- FLOAT_MULTI_PIPE_RNE_EN defined: round-to-nearest-even (increment if guard&(sticky|lsb)).
- Undefined: round-toward-zero (truncate); inexact is still reported.
- Flag, special-case and overflow behaviour are otherwise identical.

Decomposition:
- fp_pkg gains:
  - fp_flags_t packed struct {invalid, overflow, underflow, inexact}.
  - fp_class_e enum (ZERO, SUB, NORM, INF, QNAN, SNAN).
  - A classify function parametrised through the caller's field widths.
- Canonical-NaN and MAX_EXP are local params derived from fp_t.
- Sub-module: float_round. It is combinational and contains the S3 normalise/round/pack logic, reused later by the adder pipeline.

Test Plan:
- Reset and basic products, fp16, out_ready_i=1: 0x3C00 x 0x4000 -> 0x4000, flags 0, out_valid_o exactly 3 cycles after accept. Also 0x3E00 x 0x3E00 -> 0x4080.
- Rounding: 0x3C01 x 0x3E00 -> 0x3E02 with RNE_EN (tie to even), 0x3E01 without; inexact=1 in both.
- Specials:
  - 0x7C00 x 0x0000 -> 0x7E00, invalid=1.
  - 0xFC00 x 0x4000 -> 0xFC00.
  - 0x7D00 (sNaN) x 0x3C00 -> 0x7E00, invalid=1.
  - 0x7E00 x 0x3C00 -> 0x7E00, invalid=0.
- Over/underflow:
  - 0x7BFF x 0x4000 -> 0x7C00, overflow+inexact.
  - 0x0400 x 0x3800 -> 0x0000, underflow+inexact.
  - 0x8001 x 0x3C00 -> 0x8000 (DAZ).
- Backpressure: out_ready_i=0, drive 5 back-to-back requests with tags 1..5. Only 3 are accepted, then in_ready_o=0 and the held output is stable. Release: results emerge in order with tags 1..5 and none are lost or duplicated.
- Random stream with random in_valid_i/out_ready_i and a mid-stream arst_ni pulse: matches the scoreboard model, and there is no output for operations in flight at reset.
